// File: rtl/hamming_pack.sv
// Shared SECDED definitions: decoder FSM states, status flag codes and parity positions.
package hamming_pack;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CHK,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } dec_state_t;

    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_FIX = 2'b01;
    localparam logic [1:0] F_DBL = 2'b10;

    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;
    localparam int P8 = 8;

    // Gathers the 11 data bits {b11..b1} from their Hamming positions.
    function automatic logic [10:0] cw_data(input logic [15:0] cw);
        return {cw[15:9], cw[7:5], cw[3]};
    endfunction

endpackage

// File: rtl/hamming_secded_fix.sv
// Combinational SECDED check/correct for one 16-bit extended Hamming codeword.
module hamming_secded_fix
    import hamming_pack::*;
(
    input  logic [15:0] cw,
    output logic [15:0] fixed,
    output logic [1:0]  flag
);

    logic [3:0] syn;
    logic       par;

    // NOTE: every output gets a default at the top so no path through the block leaves a latch.
    always_comb begin
        syn   = '0;
        fixed = cw;
        flag  = F_OK;
        // NOTE: blocking '=' here; syn accumulates within one evaluation, unlike registered state.
        for (int i = 1; i < 16; i++) begin
            if (cw[i]) syn = syn ^ 4'(i);
        end
        par = ^cw;
        if (par) begin
            // syn==0 lands on bit 0, which is exactly the p0-only error case.
            fixed[syn] = ~cw[syn];
            flag       = F_FIX;
        end else if (syn != 4'd0) begin
            flag = F_DBL;
        end
    end

endmodule

// File: rtl/hamming_decode_engine.sv
// Memory-to-memory SECDED decoder: reads codewords byte-wise, corrects/flags, writes data+status.
module hamming_decode_engine
    import hamming_pack::*;
#(
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    mem_wdata,
    output logic          mem_wen,
    output logic [7:0]    n_single,
    output logic [7:0]    n_double
);

    dec_state_t  state;
    logic [6:0]  k;
    logic [15:0] cw;
    logic [1:0]  flag_q;
    logic [15:0] fixed;
    logic [1:0]  flag;
    logic [10:0] fixed_data;

    hamming_secded_fix u_fix (
        .cw    (cw),
        .fixed (fixed),
        .flag  (flag)
    );

    assign fixed_data = cw_data(fixed);

    // Outputs are registered: each transition loads the address/data the next state presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            cw        <= '0;
            flag_q    <= F_OK;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            n_single  <= '0;
            n_double  <= '0;
        end else begin
            // NOTE: non-blocking for all state; the default below keeps mem_wen a one-state strobe.
            mem_wen <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RD_LO;
                        k        <= '0;
                        n_single <= '0;
                        n_double <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        mem_addr <= AW'(SRC_BASE);
                    end
                end
                S_RD_LO: begin
                    cw[7:0]  <= mem_rdata;
                    mem_addr <= AW'(SRC_BASE + 2 * int'(k) + 1);
                    state    <= S_RD_HI;
                end
                S_RD_HI: begin
                    cw[15:8] <= mem_rdata;
                    state    <= S_CHK;
                end
                S_CHK: begin
                    cw        <= fixed;
                    flag_q    <= flag;
                    if (flag == F_FIX && n_single != 8'hFF) n_single <= n_single + 8'd1;
                    if (flag == F_DBL && n_double != 8'hFF) n_double <= n_double + 8'd1;
                    mem_addr  <= AW'(DST_BASE + 2 * int'(k));
                    mem_wdata <= fixed_data[7:0];
                    mem_wen   <= 1'b1;
                    state     <= S_WR_LO;
                end
                S_WR_LO: begin
                    mem_addr  <= AW'(DST_BASE + 2 * int'(k) + 1);
                    mem_wdata <= {flag_q, 3'b000, cw[15:13]};
                    mem_wen   <= 1'b1;
                    state     <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (int'(k) < NUM_WORDS - 1) begin
                        k        <= k + 7'd1;
                        mem_addr <= AW'(SRC_BASE + 2 * (int'(k) + 1));
                        state    <= S_RD_LO;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_decode_engine.sv
// Scoreboard bench for hamming_decode_engine: directed + randomly corrupted codewords, mid-run reset.
module tb_hamming_decode_engine;

    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, mem_wen;
    logic [7:0] mem_addr, mem_rdata, mem_wdata, n_single, n_double;

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t exp_wr;
    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_single, exp_double;

    hamming_decode_engine #(
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .NUM_WORDS(N),
        .AW       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .n_single (n_single),
        .n_double (n_double)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Writes are checked on the falling edge before the rising edge commits them.
    always @(negedge clk) begin
        if (rst_n && mem_wen) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_wr = sb.pop_front();
                check("wr_addr", mem_addr, exp_wr.addr);
                check("wr_data", mem_wdata, exp_wr.data);
            end
        end
    end

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            for (int i = 1; i < 16; i++) begin
                if ((i & p) != 0 && i != p) c[p] = c[p] ^ c[i];
            end
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] data_of(input logic [15:0] c);
        logic [10:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i];
                j++;
            end
        end
        return d;
    endfunction

    task automatic load_word(input int k, input logic [15:0] c, input logic [7:0] lo, input logic [7:0] hi);
        wr_t w;
        mem[8'(SRC + 2 * k)]     = c[7:0];
        mem[8'(SRC + 2 * k + 1)] = c[15:8];
        w.addr = 8'(DST + 2 * k);
        w.data = lo;
        sb.push_back(w);
        w.addr = 8'(DST + 2 * k + 1);
        w.data = hi;
        sb.push_back(w);
    endtask

    // Random word with 0, 1 or 2 injected bit errors; expectation follows from the injection.
    task automatic load_random(input int k, input int kind);
        logic [10:0] d, ed;
        logic [15:0] c;
        logic [1:0]  f;
        int a, b;
        d = 11'($urandom);
        c = encode(d);
        a = $urandom_range(15, 0);
        b = a;
        while (b == a) b = $urandom_range(15, 0);
        ed = d;
        f  = 2'b00;
        if (kind == 1) begin
            c[a] = ~c[a];
            f    = 2'b01;
            exp_single++;
        end else if (kind == 2) begin
            c[a] = ~c[a];
            c[b] = ~c[b];
            ed   = data_of(c);
            f    = 2'b10;
            exp_double++;
        end
        load_word(k, c, ed[7:0], {f, 3'b000, ed[10:8]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : main
        int         cyc;
        logic [7:0] old_hi, new_lo;

        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_nsingle", n_single, 0);
        check("rst_ndouble", n_double, 0);
        rst_n = 1'b1;

        // Run 1: five directed codewords, then mixed random ones.
        exp_single = 1 + 1;
        exp_double = 1;
        load_word(0, 16'h0000, 8'h00, 8'h00);
        load_word(1, 16'hFFFF, 8'hFF, 8'h07);
        load_word(2, 16'hFFDF, 8'hFF, 8'h47);
        load_word(3, 16'hFFFE, 8'hFF, 8'h47);
        load_word(4, 16'hFFD7, 8'hFC, 8'h87);
        for (int k = 5; k < N; k++) load_random(k, k % 3);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", busy, 1);
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 20);
        end
        start = 1'b0;
        check("done_latency", cyc, 5 * N + 1);
        check("done_level", done, 1);
        check("busy_at_done", busy, 0);
        check("run1_nsingle", n_single, exp_single);
        check("run1_ndouble", n_double, exp_double);
        check("run1_sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("done_holds", done, 1);
        check("idle_wen", mem_wen, 0);

        // Run 2 from DONE with fresh data, interrupted by reset after word 2's low byte.
        old_hi     = mem[8'(DST + 5)];
        exp_single = 0;
        exp_double = 0;
        for (int k = 0; k < N; k++) load_random(k, (k + 1) % 3);
        new_lo = sb[4].data;
        pulse_start();
        check("run2_done_cleared", done, 0);
        cyc = 0;
        while (sb.size() > 2 * N - 5 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check("run2_reached_word2", (cyc < 200), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_nsingle", n_single, 0);
        check("midrst_ndouble", n_double, 0);
        check("midrst_wen", mem_wen, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_no_wen", mem_wen, 0);
        end
        check("post_rst_busy", busy, 0);
        check("partial_lo_written", mem[8'(DST + 4)], new_lo);
        check("partial_hi_kept", mem[8'(DST + 5)], old_hi);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
